data_micro_tlb: RTL and testbench
=================================

# data_micro_tlb

Parametrised multi-entry data micro-TLB sitting in MEM1 between the load/store address path and the shared main TLB. It holds `ENTRIES` fully-associative, ASID-tagged translations (page pairs), translates mapped addresses in the same cycle on a hit, and performs kseg0/kseg1 direct mapping. On a miss it stalls the pipe and runs a req/ack refill from the main TLB. It also classifies TLB refill, invalid and modified exceptions, and supports full flush and single-VPN2 invalidation.

## Interface
- ENTRIES, 4: buffer entries, power of two, 2..16
- PFN_W, 20: physical frame number width; paddr = {PFN[19:0], vaddr[11:0]}
- clk  in  1  the single clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  memory access this cycle
- req_load  in  1  access is a load
- req_store  in  1  access is a store
- req_vaddr  in  32  virtual address
- cp0_asid  in  8  current EntryHi.ASID
- cp0_k0  in  3  Config.K0
- flush_all  in  1  invalidate all entries
- inv_valid  in  1  invalidate entries whose VPN2 equals inv_vpn2 (TLBWI/TLBWR)
- inv_vpn2  in  19  VPN2 to invalidate
- tlb_req  out  1  refill request to main TLB
- tlb_vpn2  out  19  VPN2 being refilled
- tlb_ack  in  1  main TLB response valid
- tlb_found  in  1  main TLB hit
- tlb_asid  in  8  response ASID
- tlb_g  in  1  response G bit
- tlb_pfn0, tlb_pfn1  in  PFN_W each  even/odd PFN
- tlb_c0, tlb_c1  in  3 each  even/odd cache attribute
- tlb_d0, tlb_d1, tlb_v0, tlb_v1  in  1 each  dirty/valid bits
- paddr  out  32  physical address
- cached  out  1  access is cacheable
- stall  out  1  hold MEM1, refill in progress
- except_type  out  3  0 none, 1 RdRefill, 2 RdInvalid, 3 WrRefill, 4 WrInvalid, 5 Modified

## Operation
- mem = req_valid & (req_load | req_store). Unmapped = vaddr in 0x8000_0000..0xBFFF_FFFF; all other addresses are mapped.
- Hit on entry i: valid[i] & vpn2[i]==vaddr[31:13] & (g[i] | asid[i]==cp0_asid). At most one entry hits, because fills happen only on a miss.
- paddr: kseg1 gives vaddr-0xA000_0000; kseg0 gives vaddr-0x8000_0000; mapped gives {PFN0 or PFN1 by vaddr[12], vaddr[11:0]}. On a miss, paddr is don't-care.
- cached: kseg1 gives 0; kseg0 gives cp0_k0==3; mapped gives selected C==3.
- stall = mem & mapped & ~hit.
- except_type is nonzero only when mem & mapped & hit, with this priority:
  - entry found==0 gives Refill (Rd if load, else Wr).
  - selected V==0 gives Invalid.
  - store & selected D==0 gives Modified.
  - otherwise 0.
- Entries store the main-TLB found bit, so negative results are cached and raise the refill exception.
- FSM states:
  - IDLE: if stall, latch vpn2/ASID and go to REFILL.
  - REFILL: tlb_req=1 and tlb_vpn2 is held stable until tlb_ack. On ack, write the victim entry (found, asid, g, pfn/c/d/v for both pages, valid=1) and go to IDLE.
  - DISCARD: tlb_req=1 is held until ack; the response is dropped; go to IDLE.
- Victim selection: the lowest-index invalid entry; if none is invalid, the round-robin pointer, which advances modulo ENTRIES on each such fill.
- flush_all clears all valid bits. inv_valid clears every entry matching inv_vpn2, ignoring ASID.
- If flush_all, or inv_valid with a VPN2 matching the in-flight VPN2, occurs while in REFILL and without ack, go to DISCARD.
- If ack and flush/invalidate of the same VPN2 occur in the same cycle, invalidation wins and no entry is written.
- rst: all valid bits 0, pointer 0, FSM IDLE, tlb_req 0. This applies mid-refill too; the main TLB must tolerate a dropped request on rst.

## Timing
- A hit or an unmapped access is zero-latency; all outputs are combinational from req_vaddr and the entries.
- Miss in cycle t: stall=1 at t. tlb_req=1 from t+1. If ack arrives at t+k (k>=1), the entry is written at the end of t+k, and the lookup hits at t+k+1 with stall=0. Minimum penalty is 2 cycles.
- The request must be held by the pipe while stall=1. If req_vaddr changes mid-refill, the fill still installs the latched VPN2 and the new address is looked up afresh.
- Reset values: tlb_req 0 and tlb_vpn2 0. stall, paddr, cached and except_type follow the combinational rules with empty entries: stall=1 for any mapped mem request.

## Test plan
- kseg1 load at 0xA000_1234 -> paddr 0x0000_1234, cached 0, stall 0, no tlb_req. kseg0 with k0=3 -> cached 1.
- Mapped load at 0x0040_3000 with empty buffer; ack after 3 cycles with found=1, pfn1=0x12345, v1=1, c1=3 -> stall for 5 cycles, then paddr 0x1234_5000, cached 1, except 0.
- Store to a filled page with d0=0, then with v0=0, then with found=0 -> except 5, 4 and 3 respectively. The same cases as loads -> 0, 2, 1.
- Fill ENTRIES+1 distinct VPN2s -> entries 0..N-1 are filled first, then entry 0 is replaced. Re-accessing the first VPN2 misses; the last N-1 hit.
- flush_all asserted one cycle before ack -> DISCARD state, no entry written, the request re-misses and refills again. inv_valid coincident with ack for the same VPN2 -> no install.
- Global entry (g=1) hits across an ASID change. A non-global entry with a different cp0_asid misses and refills into a second entry.

Source files
------------

// File: rtl/data_micro_tlb.sv
// Fully-associative ASID-tagged data micro-TLB with kseg0/kseg1 direct mapping; hits and unmapped
// accesses resolve in the same cycle, a miss stalls the pipe until the main-TLB refill completes.
module data_micro_tlb #(
  parameter int ENTRIES = 4,
  parameter int PFN_W   = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_load,
  input  logic             req_store,
  input  logic [31:0]      req_vaddr,
  input  logic [7:0]       cp0_asid,
  input  logic [2:0]       cp0_k0,
  input  logic             flush_all,
  input  logic             inv_valid,
  input  logic [18:0]      inv_vpn2,
  output logic             tlb_req,
  output logic [18:0]      tlb_vpn2,
  input  logic             tlb_ack,
  input  logic             tlb_found,
  input  logic [7:0]       tlb_asid,
  input  logic             tlb_g,
  input  logic [PFN_W-1:0] tlb_pfn0,
  input  logic [PFN_W-1:0] tlb_pfn1,
  input  logic [2:0]       tlb_c0,
  input  logic [2:0]       tlb_c1,
  input  logic             tlb_d0,
  input  logic             tlb_d1,
  input  logic             tlb_v0,
  input  logic             tlb_v1,
  output logic [31:0]      paddr,
  output logic             cached,
  output logic             stall,
  output logic [2:0]       except_type
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef enum logic [1:0] {IDLE, REFILL, DISCARD} state_t;

  logic [ENTRIES-1:0] ent_valid;
  logic [ENTRIES-1:0] ent_g;
  logic [ENTRIES-1:0] ent_found;
  logic [ENTRIES-1:0] ent_d0, ent_d1, ent_v0, ent_v1;
  logic [18:0]        ent_vpn2 [ENTRIES];
  logic [7:0]         ent_asid [ENTRIES];
  logic [PFN_W-1:0]   ent_pfn0 [ENTRIES];
  logic [PFN_W-1:0]   ent_pfn1 [ENTRIES];
  logic [2:0]         ent_c0   [ENTRIES];
  logic [2:0]         ent_c1   [ENTRIES];

  logic [ENTRIES-1:0] hit_vec;
  logic               hit;
  logic               sel_found, sel_d, sel_v;
  logic [PFN_W-1:0]   sel_pfn;
  logic [2:0]         sel_c;
  logic               mem, unmapped, kseg1;

  state_t             state_q, state_d;
  logic               kill, fill_we;
  logic [IDX_W-1:0]   rr_ptr, victim;
  logic               free_avail;

  // Fills only happen on a miss, so hit_vec is at most one-hot and a plain
  // last-writer mux is sufficient.
  always_comb begin
    hit_vec   = '0;
    sel_found = 1'b0;
    sel_d     = 1'b0;
    sel_v     = 1'b0;
    sel_pfn   = '0;
    sel_c     = 3'd0;
    for (int i = 0; i < ENTRIES; i++) begin
      hit_vec[i] = ent_valid[i] && (ent_vpn2[i] == req_vaddr[31:13]) &&
                   (ent_g[i] || (ent_asid[i] == cp0_asid));
      if (hit_vec[i]) begin
        sel_found = ent_found[i];
        sel_pfn   = req_vaddr[12] ? ent_pfn1[i] : ent_pfn0[i];
        sel_c     = req_vaddr[12] ? ent_c1[i]   : ent_c0[i];
        sel_d     = req_vaddr[12] ? ent_d1[i]   : ent_d0[i];
        sel_v     = req_vaddr[12] ? ent_v1[i]   : ent_v0[i];
      end
    end
  end

  assign hit      = |hit_vec;
  assign mem      = req_valid & (req_load | req_store);
  assign unmapped = (req_vaddr[31:30] == 2'b10);
  assign kseg1    = unmapped & req_vaddr[29];
  assign stall    = mem & ~unmapped & ~hit;

  always_comb begin
    paddr  = 32'({sel_pfn, req_vaddr[11:0]});
    cached = (sel_c == 3'd3);
    if (unmapped) begin
      paddr  = {3'b000, req_vaddr[28:0]};
      cached = ~kseg1 & (cp0_k0 == 3'd3);
    end
  end

  always_comb begin
    except_type = 3'd0;
    if (mem && !unmapped && hit) begin
      if (!sel_found)                except_type = req_load ? 3'd1 : 3'd3;
      else if (!sel_v)               except_type = req_load ? 3'd2 : 3'd4;
      else if (req_store && !sel_d)  except_type = 3'd5;
    end
  end

  // A flush or invalidate touching the in-flight VPN2 makes the pending response stale.
  assign kill = flush_all | (inv_valid & (inv_vpn2 == tlb_vpn2));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (stall) state_d = REFILL;
      REFILL:  if (tlb_ack) state_d = IDLE;
               else if (kill) state_d = DISCARD;
      DISCARD: if (tlb_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tlb_req = (state_q != IDLE);
    fill_we = (state_q == REFILL) & tlb_ack & ~kill;
  end

  always_ff @(posedge clk) begin
    if (rst)                           tlb_vpn2 <= '0;
    else if (state_q == IDLE && stall) tlb_vpn2 <= req_vaddr[31:13];
  end

  // Lowest-index free slot wins; scanning downward leaves it as the last assignment.
  always_comb begin
    victim     = rr_ptr;
    free_avail = 1'b0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!ent_valid[i]) begin
        victim     = IDX_W'(i);
        free_avail = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_valid <= '0;
      rr_ptr    <= '0;
    end else begin
      if (flush_all) begin
        ent_valid <= '0;
      end else if (inv_valid) begin
        for (int i = 0; i < ENTRIES; i++)
          if (ent_vpn2[i] == inv_vpn2) ent_valid[i] <= 1'b0;
      end
      if (fill_we) begin
        ent_valid[victim] <= 1'b1;
        if (!free_avail) rr_ptr <= rr_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      ent_vpn2[victim]  <= tlb_vpn2;
      ent_asid[victim]  <= tlb_asid;
      ent_g[victim]     <= tlb_g;
      ent_found[victim] <= tlb_found;
      ent_pfn0[victim]  <= tlb_pfn0;
      ent_pfn1[victim]  <= tlb_pfn1;
      ent_c0[victim]    <= tlb_c0;
      ent_c1[victim]    <= tlb_c1;
      ent_d0[victim]    <= tlb_d0;
      ent_d1[victim]    <= tlb_d1;
      ent_v0[victim]    <= tlb_v0;
      ent_v1[victim]    <= tlb_v1;
    end
  end

endmodule

// File: tb/tb_data_micro_tlb.sv
// Directed bench for data_micro_tlb: direct mapping, refill timing, exceptions, replacement,
// flush/invalidate races and ASID matching, each with hand-computed expectations.
module tb_data_micro_tlb;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_load, req_store;
  logic [31:0] req_vaddr;
  logic [7:0]  cp0_asid;
  logic [2:0]  cp0_k0;
  logic        flush_all, inv_valid;
  logic [18:0] inv_vpn2;
  logic        tlb_req;
  logic [18:0] tlb_vpn2;
  logic        tlb_ack, tlb_found, tlb_g;
  logic [7:0]  tlb_asid;
  logic [19:0] tlb_pfn0, tlb_pfn1;
  logic [2:0]  tlb_c0, tlb_c1;
  logic        tlb_d0, tlb_d1, tlb_v0, tlb_v1;
  logic [31:0] paddr;
  logic        cached, stall;
  logic [2:0]  except_type;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_micro_tlb #(.ENTRIES(4), .PFN_W(20)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_load(req_load), .req_store(req_store), .req_vaddr(req_vaddr),
    .cp0_asid(cp0_asid), .cp0_k0(cp0_k0),
    .flush_all(flush_all), .inv_valid(inv_valid), .inv_vpn2(inv_vpn2),
    .tlb_req(tlb_req), .tlb_vpn2(tlb_vpn2), .tlb_ack(tlb_ack), .tlb_found(tlb_found),
    .tlb_asid(tlb_asid), .tlb_g(tlb_g), .tlb_pfn0(tlb_pfn0), .tlb_pfn1(tlb_pfn1),
    .tlb_c0(tlb_c0), .tlb_c1(tlb_c1), .tlb_d0(tlb_d0), .tlb_d1(tlb_d1),
    .tlb_v0(tlb_v0), .tlb_v1(tlb_v1),
    .paddr(paddr), .cached(cached), .stall(stall), .except_type(except_type)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_resp(input logic f, input logic g, input logic [7:0] a,
                          input logic [19:0] p0, input logic [19:0] p1,
                          input logic [2:0] c, input logic d, input logic v);
    tlb_found = f; tlb_g = g; tlb_asid = a;
    tlb_pfn0 = p0; tlb_pfn1 = p1;
    tlb_c0 = c; tlb_c1 = c; tlb_d0 = d; tlb_d1 = d; tlb_v0 = v; tlb_v1 = v;
  endtask

  // Presents a load/store that must miss, answers the refill, and checks the follow-up hit.
  task automatic refill(input string tag, input logic [31:0] va, input logic ld,
                        input logic [7:0] ra, input logic rg, input logic rf,
                        input logic [19:0] p0, input logic [19:0] p1,
                        input logic [2:0] rc, input logic rd, input logic rv);
    int n;
    req_valid = 1'b1; req_load = ld; req_store = ~ld; req_vaddr = va;
    #1;
    chk({tag, "_miss"}, 32'(stall), 32'd1);
    n = 0;
    do begin
      step();
      n++;
    end while (!tlb_req && n < 8);
    chk({tag, "_req"}, 32'(tlb_req), 32'd1);
    chk({tag, "_vpn2"}, {13'd0, tlb_vpn2}, {13'd0, va[31:13]});
    set_resp(rf, rg, ra, p0, p1, rc, rd, rv);
    tlb_ack = 1'b1;
    step();
    tlb_ack = 1'b0;
    #1;
    chk({tag, "_hit"}, 32'(stall), 32'd0);
  endtask

  initial begin
    int stalls;
    rst = 1'b1;
    req_valid = 1'b1; req_load = 1'b1; req_store = 1'b0; req_vaddr = 32'h0040_3000;
    cp0_asid = 8'd1; cp0_k0 = 3'd3;
    flush_all = 1'b0; inv_valid = 1'b0; inv_vpn2 = '0;
    tlb_ack = 1'b0;
    set_resp(1'b0, 1'b0, 8'd0, 20'd0, 20'd0, 3'd0, 1'b0, 1'b0);
    step();
    step();
    #1;
    chk("rst_tlb_req", 32'(tlb_req), 32'd0);
    chk("rst_tlb_vpn2", {13'd0, tlb_vpn2}, 32'd0);
    chk("rst_stall_mapped", 32'(stall), 32'd1);
    req_valid = 1'b0;
    rst = 1'b0;
    step();

    // Direct-mapped segments
    req_valid = 1'b1; req_vaddr = 32'hA000_1234;
    #1;
    chk("kseg1_paddr", paddr, 32'h0000_1234);
    chk("kseg1_cached", 32'(cached), 32'd0);
    chk("kseg1_stall", 32'(stall), 32'd0);
    chk("kseg1_except", 32'(except_type), 32'd0);
    step();
    chk("kseg1_no_req", 32'(tlb_req), 32'd0);
    req_vaddr = 32'h8000_2345;
    #1;
    chk("kseg0_paddr", paddr, 32'h0000_2345);
    chk("kseg0_cached_k3", 32'(cached), 32'd1);
    cp0_k0 = 3'd2;
    #1;
    chk("kseg0_cached_k2", 32'(cached), 32'd0);
    cp0_k0 = 3'd3;
    step();

    // Mapped miss with ack on the fourth cycle after the miss: five stall cycles
    req_vaddr = 32'h0040_3000;
    #1;
    chk("miss_stall_t0", 32'(stall), 32'd1);
    chk("miss_req_t0", 32'(tlb_req), 32'd0);
    stalls = 1;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 1) begin
        chk("miss_req_t1", 32'(tlb_req), 32'd1);
        chk("miss_vpn2_t1", {13'd0, tlb_vpn2}, 32'h0000_0201);
      end
      if (k == 4) begin
        set_resp(1'b1, 1'b0, 8'd1, 20'h00000, 20'h12345, 3'd3, 1'b0, 1'b1);
        tlb_ack = 1'b1;
      end
      #1;
      if (stall) stalls++;
    end
    step();
    tlb_ack = 1'b0;
    #1;
    chk("miss_stall_cycles", 32'(stalls), 32'd5);
    chk("miss_hit_stall", 32'(stall), 32'd0);
    chk("miss_hit_paddr", paddr, 32'h1234_5000);
    chk("miss_hit_cached", 32'(cached), 32'd1);
    chk("miss_hit_except", 32'(except_type), 32'd0);

    // Exception classification
    refill("mod", 32'h0100_0000, 1'b1, 8'd1, 1'b0, 1'b1, 20'h00111, 20'h00111, 3'd3, 1'b0, 1'b1);
    chk("ld_clean_page", 32'(except_type), 32'd0);
    req_load = 1'b0; req_store = 1'b1;
    #1;
    chk("st_modified", 32'(except_type), 32'd5);
    refill("inv", 32'h0200_0000, 1'b1, 8'd1, 1'b0, 1'b1, 20'h00222, 20'h00222, 3'd3, 1'b1, 1'b0);
    chk("ld_invalid", 32'(except_type), 32'd2);
    req_load = 1'b0; req_store = 1'b1;
    #1;
    chk("st_invalid", 32'(except_type), 32'd4);
    refill("nf", 32'h0300_0000, 1'b1, 8'd1, 1'b0, 1'b0, 20'h00333, 20'h00333, 3'd3, 1'b1, 1'b1);
    chk("ld_refill", 32'(except_type), 32'd1);
    req_load = 1'b0; req_store = 1'b1;
    #1;
    chk("st_refill", 32'(except_type), 32'd3);

    // Replacement: five VPN2s into four entries after a flush
    req_valid = 1'b0; flush_all = 1'b1;
    step();
    flush_all = 1'b0;
    for (int i = 0; i < 5; i++)
      refill($sformatf("ev%0d", i), 32'h1000_0000 + i * 32'h2000, 1'b1, 8'd1, 1'b0, 1'b1,
             20'h00A00 + 20'(i), 20'h00A00 + 20'(i), 3'd3, 1'b1, 1'b1);
    for (int i = 1; i < 5; i++) begin
      step();
      req_vaddr = 32'h1000_0000 + i * 32'h2000;
      #1;
      chk($sformatf("ev_hit%0d_stall", i), 32'(stall), 32'd0);
      chk($sformatf("ev_hit%0d_paddr", i), paddr, (32'h0000_0A00 + i) << 12);
    end
    refill("ev_first_again", 32'h1000_0000, 1'b1, 8'd1, 1'b0, 1'b1, 20'h00B00, 20'h00B00, 3'd3, 1'b1, 1'b1);
    refill("ev_second_evicted", 32'h1000_2000, 1'b1, 8'd1, 1'b0, 1'b1, 20'h00B01, 20'h00B01, 3'd3, 1'b1, 1'b1);

    // flush_all one cycle before ack: response dropped, request re-misses
    step();
    req_vaddr = 32'h2000_0000; req_load = 1'b1; req_store = 1'b0;
    #1;
    chk("disc_miss", 32'(stall), 32'd1);
    step();
    chk("disc_req", 32'(tlb_req), 32'd1);
    flush_all = 1'b1;
    step();
    flush_all = 1'b0;
    set_resp(1'b1, 1'b0, 8'd1, 20'h00C00, 20'h00C00, 3'd3, 1'b1, 1'b1);
    tlb_ack = 1'b1;
    #1;
    chk("disc_req_held", 32'(tlb_req), 32'd1);
    step();
    tlb_ack = 1'b0;
    #1;
    chk("disc_no_install", 32'(stall), 32'd1);
    chk("disc_back_idle", 32'(tlb_req), 32'd0);
    step();
    chk("disc_rerequest", 32'(tlb_req), 32'd1);
    tlb_ack = 1'b1;
    step();
    tlb_ack = 1'b0;
    #1;
    chk("disc_refill_hit", 32'(stall), 32'd0);
    chk("disc_refill_paddr", paddr, 32'h00C0_0000);

    // Invalidate of the same VPN2 coincident with ack suppresses the fill
    step();
    req_vaddr = 32'h2000_2000;
    #1;
    chk("invack_miss", 32'(stall), 32'd1);
    step();
    chk("invack_req", 32'(tlb_req), 32'd1);
    set_resp(1'b1, 1'b0, 8'd1, 20'h00D00, 20'h00D00, 3'd3, 1'b1, 1'b1);
    tlb_ack = 1'b1; inv_valid = 1'b1; inv_vpn2 = 19'h10001;
    step();
    tlb_ack = 1'b0; inv_valid = 1'b0;
    #1;
    chk("invack_no_install", 32'(stall), 32'd1);
    chk("invack_idle", 32'(tlb_req), 32'd0);
    req_vaddr = 32'h2000_0000;
    #1;
    chk("invack_other_kept", 32'(stall), 32'd0);
    req_valid = 1'b0;
    step();

    // ASID matching
    refill("glob", 32'h3000_0000, 1'b1, 8'd1, 1'b1, 1'b1, 20'h00E00, 20'h00E00, 3'd3, 1'b1, 1'b1);
    cp0_asid = 8'd2;
    #1;
    chk("glob_other_asid_hit", 32'(stall), 32'd0);
    chk("glob_other_asid_paddr", paddr, 32'h00E0_0000);
    cp0_asid = 8'd1;
    step();
    refill("ng_asid1", 32'h3000_4000, 1'b1, 8'd1, 1'b0, 1'b1, 20'h00F00, 20'h00F00, 3'd3, 1'b1, 1'b1);
    cp0_asid = 8'd2;
    step();
    refill("ng_asid2", 32'h3000_4000, 1'b1, 8'd2, 1'b0, 1'b1, 20'h00F80, 20'h00F80, 3'd3, 1'b1, 1'b1);
    chk("ng_asid2_paddr", paddr, 32'h00F8_0000);
    cp0_asid = 8'd1;
    #1;
    chk("ng_asid1_still_hit", 32'(stall), 32'd0);
    chk("ng_asid1_paddr", paddr, 32'h00F0_0000);

    req_valid = 1'b0;
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
